// File: rtl/regbank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regbank_rr_arbiter
// Brief    : Round-robin arbitrated write port into a small register bank.
//            Optional owner lock enabled by defining REGARB_LOCK_EN.
// Revision : 1.0
// ============================================================================
module regbank_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int NREG  = 4,
  parameter int WIDTH = 4,
  parameter int AW    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*AW-1:0]      addr,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
`ifdef REGARB_LOCK_EN
  input  logic [N_REQ-1:0]         lock,
`endif
  output logic [N_REQ-1:0]         gnt,
  output logic [NREG-1:0]          we,
  output logic [NREG*WIDTH-1:0]    q
);

  localparam int            c_pw   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [c_pw-1:0] c_last = c_pw'(N_REQ - 1);

  logic [c_pw-1:0]  r_ptr;
  logic [c_pw-1:0]  w_ptr_nxt;
  logic [c_pw-1:0]  w_rr_win;
  logic             w_rr_found;
  logic [c_pw-1:0]  w_win;
  logic [c_pw-1:0]  w_win_inc;
  logic             w_found;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_wdata;
  int               w_idx;

  // Descending scan so the last hit is the first requester at or after r_ptr.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_win   = '0;
    w_idx      = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (req[w_idx[c_pw-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_win   = w_idx[c_pw-1:0];
      end
    end
  end

`ifdef REGARB_LOCK_EN
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_pw-1:0] r_owner;
  logic [c_pw-1:0] w_owner_nxt;

  always_comb begin
    w_found = 1'b0;
    w_win   = w_rr_win;
    if (r_state == ST_LOCKED) begin
      w_found = req[r_owner] & ~reset;
      w_win   = r_owner;
    end else begin
      w_found = w_rr_found & ~reset;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          if (lock[w_win]) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_win;
          end else begin
            w_ptr_nxt = w_win_inc;
          end
        end
      end
      ST_LOCKED: begin
        // Release on the owner's unlocked final write or when it stops requesting.
        if (!req[r_owner] || !lock[r_owner]) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = w_win_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end
`else
  assign w_found = w_rr_found & ~reset;
  assign w_win   = w_rr_win;

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_found) w_ptr_nxt = w_win_inc;
  end
`endif

  assign w_win_inc = (w_win == c_last) ? '0 : w_win + c_pw'(1);
  assign w_addr    = addr[int'(w_win)*AW +: AW];
  assign w_wdata   = wdata[int'(w_win)*WIDTH +: WIDTH];

  always_comb begin
    gnt = '0;
    we  = '0;
    if (w_found) begin
      gnt[w_win]  = 1'b1;
      we[w_addr]  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ptr <= '0;
    else       r_ptr <= w_ptr_nxt;
  end

  generate
    for (genvar r = 0; r < NREG; r++) begin : g_reg
      logic [WIDTH-1:0] r_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_q <= '0;
        else if (we[r]) r_q <= w_wdata;
      end
      assign q[r*WIDTH +: WIDTH] = r_q;
    end
  endgenerate

endmodule
`default_nettype wire
